prio_pend: RTL and testbench
============================

# prio_pend

Pending-request collector that sits directly upstream of the `bin2prio` priority stage. It latches single-cycle request pulses per lane into a sticky pending vector. It offers the highest-indexed pending lane as a registered one-hot grant plus binary index on a valid/ready handshake. On acceptance it retires that lane. The selection rule is the same as `bin2prio`: the highest-indexed '1' wins.

## Interface
- `DW`, 8, number of request lanes (≥2).
- `IW`, `$clog2(DW)`, index width (derived; not to be overridden).

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_in`  in  DW  per-lane request pulses; a 1 sets that lane pending.
- `out_ready`  in  1  consumer accepts the current offer.
- `out_valid`  out  1  an offer is presented.
- `out_onehot`  out  DW  one-hot lane being offered; all zero when `out_valid`=0.
- `out_idx`  out  IW  binary index of the offered lane; 0 when `out_valid`=0.
- `pend`  out  DW  current pending vector (registered).
- `ovf`  out  DW  sticky per-lane overflow flags (only with `PRIO_PEND_OVF_EN`).
- `ovf_clr`  in  1  clears all `ovf` bits (only with `PRIO_PEND_OVF_EN`).

## Operation
- **Accept:** `acc` = `out_valid & out_ready`.
- **Pending update:** `pend_next` = (`pend` & ~(`acc` ? `out_onehot` : 0)) | `req_in`.
  - Set wins over clear: a lane pulsed in the same cycle its grant is accepted stays pending.
- **State machine, IDLE:**
  - `out_valid`=0.
  - If `pend_next`≠0: load `out_onehot` with the highest-index bit of `pend_next` and `out_idx` with its index, then go to OFFER.
  - Otherwise remain in IDLE.
- **State machine, OFFER:**
  - `out_valid`=1.
  - If `acc`=0: `out_onehot` and `out_idx` hold unchanged, even if a higher-index request arrives. The offer is stable until accepted.
  - If `acc`=1 and `pend_next`≠0: load the new highest bit of `pend_next` and stay in OFFER (back-to-back grants).
  - If `acc`=1 and `pend_next`=0: clear `out_onehot` and `out_idx`, then go to IDLE.
- **Invariant:** while in OFFER, `out_onehot` ⊆ `pend` (always one-hot, never zero).
- **Starvation:** lower lanes can starve under sustained high-lane traffic. This is intended.
- **`out_ready` while `out_valid`=0:** ignored.

## Timing
- **Reset values:** on `rst`=1 at an edge, `pend`=0, state=IDLE, `out_valid`=0, `out_onehot`=0, `out_idx`=0, `ovf`=0.
  - Reset overrides `req_in` in the same cycle. A pulse coincident with reset is lost.
- **Request latency:** `req_in` pulse in cycle t → `pend` and `out_valid` visible in cycle t+1.
- **Throughput:** one grant per cycle with `out_ready` held high.
- **Outputs:** all outputs are registered. There is no combinational path from `req_in` or `out_ready` to any output.
- **Reset mid-offer:** the offer is dropped and lanes are not replayed.

## Configuration
- **Macro `PRIO_PEND_OVF_EN` defined:**
  - Adds the `ovf` and `ovf_clr` ports.
  - `ovf[i]` sets when `req_in[i]`=1 while `pend[i]`=1 and lane i is not being accepted that cycle (the request merges into an already-pending lane).
  - `ovf_clr` clears all bits. A set in the same cycle as `ovf_clr` wins.
- **Macro not defined:**
  - The ports are absent.
  - Duplicate requests merge silently.
  - No additional flops.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with `req_in`=8'hFF → `out_valid`=0, `out_onehot`=0, `out_idx`=0, `pend`=0 after reset.
- **Single lane:** `req_in`=8'h04 for one cycle, `out_ready`=1 → next cycle `out_valid`=1, `out_onehot`=8'h04, `out_idx`=2. The cycle after: `out_valid`=0, `pend`=0.
- **Drain order:** `req_in`=8'b00110110 for one cycle, `out_ready`=1 → four consecutive grants:
  - 8'h20 (idx 5), 8'h10 (idx 4), 8'h04 (idx 2), 8'h02 (idx 1);
  - then `out_valid`=0.
- **Stall stability:**
  - `out_ready`=0, `req_in`=8'h01 → offer 8'h01.
  - Then `req_in`=8'h80 during the stall → offer stays 8'h01 and `pend`=8'h81.
  - Raise `out_ready` → grants 8'h01 then 8'h80.
- **Set/clear collision:** while offering 8'h08, `out_ready`=1 and `req_in`=8'h08 in the same cycle → next cycle offers 8'h08 again, `idx`=3.
- **Overflow (`PRIO_PEND_OVF_EN`):**
  - `out_ready`=0, `req_in`=8'h02 for two consecutive cycles → `ovf`=8'h02.
  - `ovf_clr`=1 → `ovf`=0 next cycle.
  - `rst` mid-offer → all outputs zero next cycle.

Source files
------------

// File: rtl/prio_pend.sv
// Sticky pending-request collector offering the highest-indexed pending lane
// on a registered valid/ready handshake. Optional overflow flags: PRIO_PEND_OVF_EN.
module prio_pend #(
    parameter  int DW = 8,
    localparam int IW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] req_in,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_onehot,
    output logic [IW-1:0] out_idx,
`ifdef PRIO_PEND_OVF_EN
    output logic [DW-1:0] ovf,
    input  logic          ovf_clr,
`endif
    output logic [DW-1:0] pend
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // Highest-index set bit wins; later loop iterations override earlier ones.
    function automatic logic [DW-1:0] msb_onehot(input logic [DW-1:0] v);
        logic [DW-1:0] oh;
        oh = {DW{1'b0}};
        for (int i = 0; i < DW; i++) begin
            if (v[i]) begin
                oh    = {DW{1'b0}};
                oh[i] = 1'b1;
            end else begin
                oh = oh;
            end
        end
        return oh;
    endfunction

    function automatic logic [IW-1:0] msb_idx(input logic [DW-1:0] v);
        logic [IW-1:0] idx;
        idx = {IW{1'b0}};
        for (int i = 0; i < DW; i++) begin
            if (v[i]) begin
                idx = IW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t        state_q, state_d;
    logic [DW-1:0] pend_q, pend_d;
    logic [DW-1:0] onehot_q, onehot_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          acc_s;
    logic [DW-1:0] retire_s;

    // Acceptance, pending update (set wins over retire) and offer FSM next state.
    always_comb begin
        acc_s    = (state_q == OFFER) & out_ready;
        retire_s = acc_s ? onehot_q : {DW{1'b0}};
        pend_d   = (pend_q & ~retire_s) | req_in;
        state_d  = state_q;
        onehot_d = onehot_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (|pend_d) begin
                    onehot_d = msb_onehot(pend_d);
                    idx_d    = msb_idx(pend_d);
                    state_d  = OFFER;
                end else begin
                    state_d  = IDLE;
                end
            end
            OFFER: begin
                // An unaccepted offer is frozen even if a higher lane arrives.
                if (acc_s) begin
                    if (|pend_d) begin
                        onehot_d = msb_onehot(pend_d);
                        idx_d    = msb_idx(pend_d);
                        state_d  = OFFER;
                    end else begin
                        onehot_d = {DW{1'b0}};
                        idx_d    = {IW{1'b0}};
                        state_d  = IDLE;
                    end
                end else begin
                    state_d = OFFER;
                end
            end
            default: begin
                onehot_d = {DW{1'b0}};
                idx_d    = {IW{1'b0}};
                state_d  = IDLE;
            end
        endcase
    end

    // State and offer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pend_q   <= {DW{1'b0}};
            onehot_q <= {DW{1'b0}};
            idx_q    <= {IW{1'b0}};
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            onehot_q <= onehot_d;
            idx_q    <= idx_d;
        end
    end

`ifdef PRIO_PEND_OVF_EN
    logic [DW-1:0] ovf_q, ovf_d;

    // A request landing on a still-pending, non-retiring lane is an overflow; set beats clear.
    always_comb begin
        ovf_d = (ovf_clr ? {DW{1'b0}} : ovf_q) | (req_in & pend_q & ~retire_s);
    end

    // Sticky overflow register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= {DW{1'b0}};
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign out_valid  = (state_q == OFFER);
    assign out_onehot = onehot_q;
    assign out_idx    = idx_q;
    assign pend       = pend_q;

endmodule

// File: tb/tb_prio_pend.sv
// Self-checking bench for prio_pend: directed literal checks plus randomized
// traffic compared every cycle against a lane-number-based reference model.
module tb_prio_pend;

    localparam int DW = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] req_in;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_onehot;
    logic [IW-1:0] out_idx;
    logic [DW-1:0] pend;
`ifdef PRIO_PEND_OVF_EN
    logic [DW-1:0] ovf;
    logic          ovf_clr;
`endif

    always #5 clk = ~clk;

    prio_pend #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_onehot (out_onehot),
        .out_idx    (out_idx),
`ifdef PRIO_PEND_OVF_EN
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
`endif
        .pend       (pend)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending set, whether an offer is live, and which lane.
    logic [DW-1:0] m_pend = '0;
    logic [DW-1:0] m_ovf  = '0;
    bit            m_valid = 1'b0;
    int            m_lane  = 0;

    function automatic int top_lane(input logic [DW-1:0] v);
        for (int i = DW - 1; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [DW-1:0] r, input bit rdy, input bit rs, input bit clr);
        logic [DW-1:0] np;
        bit acc;
        if (rs) begin
            m_pend  = '0;
            m_ovf   = '0;
            m_valid = 1'b0;
            m_lane  = 0;
        end else begin
            acc = m_valid && rdy;
            np  = m_pend;
            if (acc) np[m_lane] = 1'b0;
            np = np | r;
            if (clr) m_ovf = '0;
            for (int i = 0; i < DW; i++) begin
                if (r[i] && m_pend[i] && !(acc && m_lane == i)) m_ovf[i] = 1'b1;
            end
            if (!m_valid || acc) begin
                m_valid = (np != '0);
                m_lane  = m_valid ? top_lane(np) : 0;
            end
            m_pend = np;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare #1 later.
    task automatic step(input logic [DW-1:0] r, input bit rdy, input bit rs, input bit clr);
        logic [DW-1:0] exp_oh;
        req_in    = r;
        out_ready = rdy;
        rst       = rs;
`ifdef PRIO_PEND_OVF_EN
        ovf_clr   = clr;
`endif
        @(posedge clk);
        model_edge(r, rdy, rs, clr);
        #1;
        exp_oh = '0;
        if (m_valid) exp_oh[m_lane] = 1'b1;
        check("out_valid",  32'(out_valid),  32'(m_valid));
        check("out_onehot", 32'(out_onehot), 32'(exp_oh));
        check("out_idx",    32'(out_idx),    m_valid ? 32'(m_lane) : 32'd0);
        check("pend",       32'(pend),       32'(m_pend));
`ifdef PRIO_PEND_OVF_EN
        check("ovf",        32'(ovf),        32'(m_ovf));
`endif
    endtask

    initial begin
        rst = 1'b1; req_in = '0; out_ready = 1'b0;
`ifdef PRIO_PEND_OVF_EN
        ovf_clr = 1'b0;
`endif
        // Reset with all lanes pulsing: everything lost.
        step(8'hFF, 1'b0, 1'b1, 1'b0);
        step(8'hFF, 1'b0, 1'b1, 1'b0);
        check("rst_valid",  32'(out_valid),  32'd0);
        check("rst_onehot", 32'(out_onehot), 32'd0);
        check("rst_idx",    32'(out_idx),    32'd0);
        check("rst_pend",   32'(pend),       32'd0);

        // Single lane.
        step(8'h04, 1'b1, 1'b0, 1'b0);
        check("single_valid",  32'(out_valid),  32'd1);
        check("single_onehot", 32'(out_onehot), 32'h04);
        check("single_idx",    32'(out_idx),    32'd2);
        step(8'h00, 1'b1, 1'b0, 1'b0);
        check("single_done",   32'(out_valid),  32'd0);
        check("single_pend",   32'(pend),       32'd0);

        // Drain order 5,4,2,1.
        step(8'b0011_0110, 1'b1, 1'b0, 1'b0);
        check("drain0_oh",  32'(out_onehot), 32'h20);
        check("drain0_idx", 32'(out_idx),    32'd5);
        step(8'h00, 1'b1, 1'b0, 1'b0);
        check("drain1_oh",  32'(out_onehot), 32'h10);
        check("drain1_idx", 32'(out_idx),    32'd4);
        step(8'h00, 1'b1, 1'b0, 1'b0);
        check("drain2_oh",  32'(out_onehot), 32'h04);
        check("drain2_idx", 32'(out_idx),    32'd2);
        step(8'h00, 1'b1, 1'b0, 1'b0);
        check("drain3_oh",  32'(out_onehot), 32'h02);
        check("drain3_idx", 32'(out_idx),    32'd1);
        step(8'h00, 1'b1, 1'b0, 1'b0);
        check("drain_end",  32'(out_valid),  32'd0);

        // Stall stability: a higher lane must not preempt a held offer.
        step(8'h01, 1'b0, 1'b0, 1'b0);
        check("stall0_oh",  32'(out_onehot), 32'h01);
        step(8'h80, 1'b0, 1'b0, 1'b0);
        check("stall1_oh",  32'(out_onehot), 32'h01);
        check("stall1_pnd", 32'(pend),       32'h81);
        step(8'h00, 1'b1, 1'b0, 1'b0);
        check("stall2_oh",  32'(out_onehot), 32'h80);
        step(8'h00, 1'b1, 1'b0, 1'b0);
        check("stall_end",  32'(out_valid),  32'd0);

        // Set/clear collision re-offers the same lane.
        step(8'h08, 1'b1, 1'b0, 1'b0);
        check("coll0_oh",   32'(out_onehot), 32'h08);
        step(8'h08, 1'b1, 1'b0, 1'b0);
        check("coll1_oh",   32'(out_onehot), 32'h08);
        check("coll1_idx",  32'(out_idx),    32'd3);
        step(8'h00, 1'b1, 1'b0, 1'b0);
        check("coll_end",   32'(out_valid),  32'd0);

`ifdef PRIO_PEND_OVF_EN
        step(8'h02, 1'b0, 1'b0, 1'b0);
        check("ovf0", 32'(ovf), 32'h00);
        step(8'h02, 1'b0, 1'b0, 1'b0);
        check("ovf1", 32'(ovf), 32'h02);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        check("ovf_clr", 32'(ovf), 32'h00);
`endif

        // Reset mid-offer drops everything.
        step(8'h40, 1'b0, 1'b0, 1'b0);
        check("mid_offer",  32'(out_valid),  32'd1);
        step(8'h10, 1'b1, 1'b1, 1'b0);
        check("mid_rst_v",  32'(out_valid),  32'd0);
        check("mid_rst_oh", 32'(out_onehot), 32'd0);
        check("mid_rst_p",  32'(pend),       32'd0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [DW-1:0] r;
            r = DW'($urandom & $urandom);
            if ($urandom_range(0, 3) == 0) r = '0;
            step(r, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
                 $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
